lcd_bus_rx: RTL
===============

Name: lcd_bus_rx

Overview:
- Responder/monitor end of the HD44780-style parallel LCD bus driven by lcd_ctrl.
- Synchronises the bus pins and detects each LCD_EN strobe. Checks every strobe against the bus timing (address setup, pulse width, cycle time).
- Captures each strobe's RS/RW/DATA into a small FIFO, read out over a valid/ready interface.
- Used as an on-chip LCD emulator and as a loopback checker for the LCD path of the SoC.

Parameters:
- T_PERIOD_NS, 40, clock period in ns.
- T_AS_NS, 80, minimum RS/RW setup before EN rise; AS_CYC = ceil(T_AS_NS/T_PERIOD_NS) = 2.
- T_PW_NS, 460, minimum EN high width; PW_CYC = ceil(T_PW_NS/T_PERIOD_NS) = 12.
- T_CYCE_NS, 1000, minimum EN rise-to-rise period; CYCE_CYC = ceil(T_CYCE_NS/T_PERIOD_NS) = 25.
- SYNC_STAGES, 2, synchroniser depth on all bus inputs (>=2).
- FIFO_DEPTH, 4, capture FIFO entries (power of 2).

Ports:
- i_clk  in  1  single clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_LCD_DATA  in  8  bus data.
- i_LCD_RW  in  1  1=read, 0=write.
- i_LCD_RS  in  1  1=data, 0=command.
- i_LCD_EN  in  1  enable strobe.
- i_LCD_ON  in  1  display power; 0 gates monitoring.
- o_vld  out  1  FIFO head valid.
- i_rdy  in  1  consumer ready.
- o_data  out  8  head DATA (0 for reads).
- o_rs  out  1  head RS.
- o_rw  out  1  head RW.
- o_err_setup  out  1  sticky setup violation.
- o_err_pw  out  1  sticky pulse-width violation.
- o_err_cyc  out  1  sticky cycle-time violation.
- o_ovf  out  1  sticky FIFO overflow.
- i_err_clr  in  1  clears all sticky flags.
- o_strb_cnt  out  16  strobes detected, wraps at 16 bits.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM=IDLE, sync chains 0, first_strobe flag set.
- Sync: all five bus inputs pass through SYNC_STAGES flops; en_d is the delayed copy of synced EN. Rise = en_s & ~en_d; fall = ~en_s & en_d.
- Setup counter: cleared when synced RS or RW differs from the previous cycle, else +1, saturating at AS_CYC.
- Period counter: cleared on rise, else +1, saturating at CYCE_CYC.
- FSM IDLE to HIGH on rise with on_s=1:
  - err_setup set if setup counter < AS_CYC.
  - err_cyc set if period counter < CYCE_CYC and first_strobe=0; first_strobe then cleared.
  - pw counter set to 1; o_strb_cnt +1.
- FSM in HIGH:
  - pw counter +1 each cycle en_s=1, saturating at PW_CYC.
  - Each cycle latch synced RS/RW/DATA into a capture register, so the capture holds the values from the last high cycle.
- FSM HIGH to IDLE on fall:
  - err_pw set if pw counter < PW_CYC.
  - Record {data, rs, rw} pushed at the next edge; data forced to 0 when rw=1.
- on_s drops while in HIGH: go to IDLE immediately, no push, no pw check.
- on_s=0: rises ignored, no counters/flags update, first_strobe set.
- Latency: o_vld rises SYNC_STAGES+2 rising edges after the first edge sampling i_LCD_EN low (FIFO empty).
- FIFO:
  - o_vld = not empty; pop when o_vld & i_rdy.
  - Push accepted if not full or pop in the same cycle; otherwise record dropped and o_ovf set.
  - Outputs come straight from the head entry; pointers wrap modulo FIFO_DEPTH.
- Sticky flags: i_err_clr clears; a new violation in the same cycle wins (flag stays 1). i_err_clr does not flush the FIFO or reset o_strb_cnt.
- Async reset mid-strobe: everything returns to reset state; the partial strobe is lost.

Test Plan:
- Legal write: RS=1, DATA=0x41 held 3 cycles, EN high 12 cycles, period 25 -> one record {0x41, rs=1, rw=0}. o_vld 4 edges after EN low, no errors, o_strb_cnt=1.
- Short pulse: EN high 8 cycles, else legal -> record captured, o_err_pw=1. i_err_clr pulse -> 0.
- Setup/cycle: RS toggles 1 cycle before EN rise, and second strobe rises 20 cycles after the first -> o_err_setup=1 and o_err_cyc=1.
- Overflow: i_rdy=0, 5 legal strobes DATA 0x01..0x05 -> FIFO holds 0x01..0x04, o_ovf=1. Then i_rdy=1 -> four pops in order, o_vld=0.
- Gating: LCD_ON=0 during strobe, then LCD_ON drops mid-pulse on the next -> no records, no errors, o_strb_cnt counts only the second rise.
- Read strobe: RW=1, DATA=0xFF -> record {0x00, rs, rw=1}. Async reset asserted mid-HIGH -> all outputs 0, FIFO empty.

Source files
------------

// File: rtl/lcd_bus_rx.sv
// Receive/monitor end of an HD44780-style parallel LCD bus. It synchronises the pins and checks
// each EN strobe against the bus timing limits. Captured cycles are queued in a small FIFO.
module lcd_bus_rx #(
  parameter int unsigned T_PERIOD_NS = 40,
  parameter int unsigned T_AS_NS     = 80,
  parameter int unsigned T_PW_NS     = 460,
  parameter int unsigned T_CYCE_NS   = 1000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_LCD_DATA,
  input  logic        i_LCD_RW,
  input  logic        i_LCD_RS,
  input  logic        i_LCD_EN,
  input  logic        i_LCD_ON,
  output logic        o_vld,
  input  logic        i_rdy,
  output logic [7:0]  o_data,
  output logic        o_rs,
  output logic        o_rw,
  output logic        o_err_setup,
  output logic        o_err_pw,
  output logic        o_err_cyc,
  output logic        o_ovf,
  input  logic        i_err_clr,
  output logic [15:0] o_strb_cnt
);

  localparam int unsigned AS_CYC   = (T_AS_NS + T_PERIOD_NS - 1) / T_PERIOD_NS;
  localparam int unsigned PW_CYC   = (T_PW_NS + T_PERIOD_NS - 1) / T_PERIOD_NS;
  localparam int unsigned CYCE_CYC = (T_CYCE_NS + T_PERIOD_NS - 1) / T_PERIOD_NS;
  localparam int unsigned AS_W     = $clog2(AS_CYC + 1);
  localparam int unsigned PW_W     = $clog2(PW_CYC + 1);
  localparam int unsigned CY_W     = $clog2(CYCE_CYC + 1);
  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned BUS_W    = 12;
  localparam int unsigned REC_W    = 10;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_HIGH = 1'b1} state_e;

  logic [SYNC_STAGES-1:0][BUS_W-1:0] sync_q;
  logic [BUS_W-1:0] bus_s;
  logic [7:0]       data_s;
  logic             rw_s, rs_s, en_s, on_s;

  state_e           state_q;
  logic             en_d_q, rs_p_q, rw_p_q, first_q;
  logic [AS_W-1:0]  su_q, su_d, su_inc_s;
  logic [CY_W-1:0]  pc_q, pc_d, pc_inc_s;
  logic [PW_W-1:0]  pw_q;
  logic [7:0]       cap_data_q;
  logic             cap_rs_q, cap_rw_q;
  logic             push_q;
  logic [REC_W-1:0] rec_q;
  logic [15:0]      strb_q;
  logic             err_setup_q, err_pw_q, err_cyc_q, ovf_q;

  logic             rise_s, fall_s, chg_s, act_rise_s, act_fall_s;
  logic             set_setup_s, set_cyc_s, set_pw_s;

  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, pop_s, full_s, wr_ok_s, ovf_set_s;

  assign bus_s = sync_q[SYNC_STAGES-1];
  assign {on_s, en_s, rs_s, rw_s, data_s} = bus_s;

  // Bus synchroniser: every pin goes through the same number of stages so their skew is preserved
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {i_LCD_ON, i_LCD_EN, i_LCD_RS, i_LCD_RW, i_LCD_DATA}};
    end
  end

  // Edge detection, timing counters and violation decode. The checks use the count including
  // the current cycle, so a signal stable for exactly AS_CYC cycles counts as met.
  always_comb begin
    rise_s = en_s & ~en_d_q;
    fall_s = ~en_s & en_d_q;
    chg_s  = (rs_s != rs_p_q) | (rw_s != rw_p_q);
    if (su_q == AS_W'(AS_CYC)) begin
      su_inc_s = su_q;
    end else begin
      su_inc_s = su_q + AS_W'(1);
    end
    if (pc_q == CY_W'(CYCE_CYC)) begin
      pc_inc_s = pc_q;
    end else begin
      pc_inc_s = pc_q + CY_W'(1);
    end
    if (!on_s) begin
      su_d = su_q;
      pc_d = pc_q;
    end else begin
      su_d = chg_s ? '0 : su_inc_s;
      pc_d = rise_s ? '0 : pc_inc_s;
    end
    act_rise_s  = (state_q == ST_IDLE) & on_s & rise_s;
    act_fall_s  = (state_q == ST_HIGH) & on_s & fall_s;
    set_setup_s = act_rise_s & (su_d < AS_W'(AS_CYC));
    set_cyc_s   = act_rise_s & ~first_q & (pc_inc_s < CY_W'(CYCE_CYC));
    set_pw_s    = act_fall_s & (pw_q < PW_W'(PW_CYC));
  end

  // Strobe FSM with capture register and record hand-off to the FIFO
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      en_d_q     <= 1'b0;
      rs_p_q     <= 1'b0;
      rw_p_q     <= 1'b0;
      su_q       <= '0;
      pc_q       <= '0;
      pw_q       <= '0;
      first_q    <= 1'b1;
      cap_data_q <= 8'h00;
      cap_rs_q   <= 1'b0;
      cap_rw_q   <= 1'b0;
      push_q     <= 1'b0;
      rec_q      <= '0;
      strb_q     <= 16'd0;
    end else begin
      en_d_q <= en_s;
      rs_p_q <= rs_s;
      rw_p_q <= rw_s;
      su_q   <= su_d;
      pc_q   <= pc_d;
      push_q <= 1'b0;
      if (!on_s) begin
        first_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (act_rise_s) begin
            state_q    <= ST_HIGH;
            pw_q       <= PW_W'(1);
            first_q    <= 1'b0;
            strb_q     <= strb_q + 16'd1;
            cap_data_q <= data_s;
            cap_rs_q   <= rs_s;
            cap_rw_q   <= rw_s;
          end
        end
        ST_HIGH: begin
          if (!on_s) begin
            state_q <= ST_IDLE;
          end else if (fall_s) begin
            state_q <= ST_IDLE;
            push_q  <= 1'b1;
            rec_q   <= {(cap_rw_q ? 8'h00 : cap_data_q), cap_rs_q, cap_rw_q};
          end else begin
            if (pw_q != PW_W'(PW_CYC)) begin
              pw_q <= pw_q + PW_W'(1);
            end
            cap_data_q <= data_s;
            cap_rs_q   <= rs_s;
            cap_rw_q   <= rw_s;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky flags: a violation in the same cycle as a clear keeps the flag set
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_setup_q <= 1'b0;
      err_pw_q    <= 1'b0;
      err_cyc_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      err_setup_q <= (err_setup_q & ~i_err_clr) | set_setup_s;
      err_pw_q    <= (err_pw_q & ~i_err_clr) | set_pw_s;
      err_cyc_q   <= (err_cyc_q & ~i_err_clr) | set_cyc_s;
      ovf_q       <= (ovf_q & ~i_err_clr) | ovf_set_s;
    end
  end

  // FIFO occupancy; a push into a full FIFO still fits when the head leaves in the same cycle
  always_comb begin
    pop_s     = vld_q & i_rdy;
    full_s    = (cnt_q == CNT_W'(FIFO_DEPTH));
    wr_ok_s   = push_q & (~full_s | pop_s);
    ovf_set_s = push_q & ~wr_ok_s;
    case ({wr_ok_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage and pointers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        mem_q[wr_ptr_q] <= rec_q;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      cnt_q <= cnt_d;
      vld_q <= (cnt_d != '0);
    end
  end

  assign o_vld                  = vld_q;
  assign {o_data, o_rs, o_rw}   = mem_q[rd_ptr_q];
  assign o_err_setup            = err_setup_q;
  assign o_err_pw               = err_pw_q;
  assign o_err_cyc              = err_cyc_q;
  assign o_ovf                  = ovf_q;
  assign o_strb_cnt             = strb_q;

endmodule
